// File: rtl/conv2_window_gen_pkg.sv
// rtl/conv2_window_gen_pkg.sv - default geometry, FSM states and window packing index for conv2_window_gen
package conv2_window_gen_pkg;

  localparam int CI_DEF  = 3;
  localparam int KX_DEF  = 5;
  localparam int KY_DEF  = 5;
  localparam int IBW_DEF = 8;
  localparam int IW_DEF  = 12;
  localparam int IH_DEF  = 12;

  typedef enum logic {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Sample (c,ky,kx) position inside the packed window, in units of one sample.
  function automatic int win_idx(input int c, input int ky, input int kx,
                                 input int ky_n, input int kx_n);
    return (c * ky_n + ky) * kx_n + kx;
  endfunction

endpackage

// File: rtl/conv2_line_buf.sv
// rtl/conv2_line_buf.sv - one image row of pixels, same-address read-before-write
module conv2_line_buf #(
  parameter int W     = 24,
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Asynchronous read returns the old word in the same cycle it is overwritten.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/conv2_window_gen.sv
// rtl/conv2_window_gen.sv - raster-scan KX x KY sliding window generator feeding the conv2 core
module conv2_window_gen
  import conv2_window_gen_pkg::*;
#(
  parameter int CI  = CI_DEF,
  parameter int KX  = KX_DEF,
  parameter int KY  = KY_DEF,
  parameter int IBW = IBW_DEF,
  parameter int IW  = IW_DEF,
  parameter int IH  = IH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_flush,
  input  logic                    i_in_valid,
  input  logic [CI*IBW-1:0]       i_in_pixel,
  output logic                    o_ot_valid,
  output logic [CI*KX*KY*IBW-1:0] o_ot_fmap,
  output logic                    o_frame_done
);

  localparam int PW = CI * IBW;
  localparam int CW = (IW > 1) ? $clog2(IW) : 1;
  localparam int RW = (IH > 1) ? $clog2(IH) : 1;

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  state_t        state, state_nxt;
  logic          accept, col_last, row_last, win_valid;

  logic [PW-1:0] lb_rd [KY-1];
  logic [PW-1:0] lb_wd [KY-1];
  logic [PW-1:0] win     [KX-1][KY];
  logic [PW-1:0] win_nxt [KX][KY];
  logic [CI*KX*KY*IBW-1:0] fmap_nxt;

  assign accept    = i_in_valid & ~i_flush & reset_n;
  assign col_last  = (col == CW'(IW - 1));
  assign row_last  = (row == RW'(IH - 1));
  assign win_valid = accept && (state == S_RUN) && (col >= CW'(KX - 1));

  // Rows cascade upward: the newest buffer takes the pixel, each older one takes its neighbour's old word.
  for (genvar k = 0; k < KY - 1; k++) begin : g_lb
    if (k == KY - 2) begin : g_head
      assign lb_wd[k] = i_in_pixel;
    end else begin : g_tail
      assign lb_wd[k] = lb_rd[k+1];
    end
    conv2_line_buf #(.W(PW), .DEPTH(IW), .AW(CW)) u_line_buf (
      .clk   (clk),
      .we    (accept),
      .addr  (col),
      .wdata (lb_wd[k]),
      .rdata (lb_rd[k])
    );
  end

  always_comb begin
    for (int kx = 0; kx < KX - 1; kx++) win_nxt[kx] = win[kx];
    for (int ky = 0; ky < KY - 1; ky++) win_nxt[KX-1][ky] = lb_rd[ky];
    win_nxt[KX-1][KY-1] = i_in_pixel;
  end

  always_comb begin
    fmap_nxt = '0;
    for (int c = 0; c < CI; c++)
      for (int ky = 0; ky < KY; ky++)
        for (int kx = 0; kx < KX; kx++)
          fmap_nxt[win_idx(c, ky, kx, KY, KX)*IBW +: IBW] = win_nxt[kx][ky][c*IBW +: IBW];
  end

  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_FILL:  if (col_last && row == RW'(KY - 2)) state_nxt = S_RUN;
        S_RUN:   if (col_last && row_last)           state_nxt = S_FILL;
        default: state_nxt = S_FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      state        <= S_FILL;
      col          <= '0;
      row          <= '0;
      o_ot_valid   <= 1'b0;
      o_frame_done <= 1'b0;
      o_ot_fmap    <= '0;
    end else begin
      state        <= state_nxt;
      o_ot_valid   <= win_valid;
      o_frame_done <= win_valid && col_last && row_last;
      if (win_valid) o_ot_fmap <= fmap_nxt;
      if (accept) begin
        if (col_last) begin
          col <= '0;
          row <= row_last ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  // Window storage is pure datapath; stale contents are flushed out by KX shifts before any valid window.
  always_ff @(posedge clk) begin
    if (accept)
      for (int j = 0; j < KX - 1; j++) win[j] <= win_nxt[j+1];
  end

endmodule

// File: tb/tb_conv2_window_gen.sv
// tb/tb_conv2_window_gen.sv - scoreboard and table-driven bench for conv2_window_gen
module tb_conv2_window_gen;

  localparam int AW_IMG = 8;
  localparam int AK     = 3;
  localparam int ACI    = 2;
  localparam int BW_IMG = 12;
  localparam int BK     = 5;
  localparam int BCI    = 3;
  localparam int AFW    = ACI * AK * AK * 8;
  localparam int BFW    = BCI * BK * BK * 8;

  typedef struct {
    logic [599:0] fmap;
    logic         done;
    int           cyc;
  } exp_t;

  typedef struct {
    int idx;
    int v[9];
    bit done;
  } vec_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           a_flush, a_valid_i, b_flush, b_valid_i;
  logic [15:0]    a_pix;
  logic [23:0]    b_pix;
  logic           a_valid, a_done, b_valid, b_done;
  logic [AFW-1:0] a_fmap;
  logic [BFW-1:0] b_fmap;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n_win_a = 0, n_done_a = 0, n_win_b = 0, n_done_b = 0;
  bit   cap_en = 1'b0;
  exp_t q_a[$];
  exp_t q_b[$];
  logic [AFW-1:0] cap_f[$];
  bit   cap_d[$];
  vec_t vec[5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv2_window_gen #(.CI(ACI), .KX(AK), .KY(AK), .IBW(8), .IW(AW_IMG), .IH(AW_IMG)) dut_a (
    .clk(clk), .reset_n(reset_n), .i_flush(a_flush), .i_in_valid(a_valid_i), .i_in_pixel(a_pix),
    .o_ot_valid(a_valid), .o_ot_fmap(a_fmap), .o_frame_done(a_done)
  );

  conv2_window_gen dut_b (
    .clk(clk), .reset_n(reset_n), .i_flush(b_flush), .i_in_valid(b_valid_i), .i_in_pixel(b_pix),
    .o_ot_valid(b_valid), .o_ot_fmap(b_fmap), .o_frame_done(b_done)
  );

  task automatic check(input bit ok, input string name, input logic [599:0] act, input logic [599:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int base, input int r, input int c, input int ch, input int iw);
    return 8'(base + r * iw + c + ch * 64);
  endfunction

  function automatic logic [599:0] exp_win(input int base, input int r, input int c, input int iw,
                                           input int kn, input int cin);
    logic [599:0] w;
    w = '0;
    for (int ch = 0; ch < cin; ch++)
      for (int ky = 0; ky < kn; ky++)
        for (int kx = 0; kx < kn; kx++)
          w[((ch * kn + ky) * kn + kx) * 8 +: 8] = pix(base, r - kn + 1 + ky, c - kn + 1 + kx, ch, iw);
    return w;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (a_valid) begin
      n_win_a++;
      if (a_done) n_done_a++;
      if (cap_en) begin
        cap_f.push_back(a_fmap);
        cap_d.push_back(a_done);
      end
      if (q_a.size() == 0) begin
        check(1'b0, "a_unexpected_window", 600'(a_fmap), '0);
      end else begin
        e = q_a.pop_front();
        check(a_fmap == e.fmap[AFW-1:0] && a_done == e.done && cyc == e.cyc + 1, "a_window",
              {a_fmap, 32'(cyc), 7'd0, a_done}, {e.fmap[AFW-1:0], 32'(e.cyc + 1), 7'd0, e.done});
      end
    end else if (a_done === 1'b1) begin
      check(1'b0, "a_done_without_valid", 600'(a_done), '0);
    end
    if (b_valid) begin
      n_win_b++;
      if (b_done) n_done_b++;
      if (q_b.size() == 0) begin
        check(1'b0, "b_unexpected_window", 600'(b_fmap), '0);
      end else begin
        e = q_b.pop_front();
        check(b_fmap == e.fmap && b_done == e.done && cyc == e.cyc + 1, "b_window",
              600'(b_fmap), e.fmap);
      end
    end else if (b_done === 1'b1) begin
      check(1'b0, "b_done_without_valid", 600'(b_done), '0);
    end
  end

  task automatic drive_a(input bit v, input bit fl, input logic [15:0] px);
    @(posedge clk);
    #1;
    a_valid_i = v;
    a_flush   = fl;
    a_pix     = px;
  endtask

  task automatic idle_a(input int n);
    for (int i = 0; i < n; i++) drive_a(1'b0, 1'b0, '0);
  endtask

  task automatic frame_a(input int base, input int gap_pct, input int stop_r, input int stop_c);
    exp_t e;
    for (int r = 0; r < AW_IMG; r++) begin
      for (int c = 0; c < AW_IMG; c++) begin
        if (r == stop_r && c == stop_c) return;
        while (gap_pct > 0 && $urandom_range(99) < gap_pct) drive_a(1'b0, 1'b0, '0);
        drive_a(1'b1, 1'b0, {pix(base, r, c, 1, AW_IMG), pix(base, r, c, 0, AW_IMG)});
        if (r >= AK - 1 && c >= AK - 1) begin
          e.fmap = exp_win(base, r, c, AW_IMG, AK, ACI);
          e.done = (r == AW_IMG - 1) && (c == AW_IMG - 1);
          e.cyc  = cyc;
          q_a.push_back(e);
        end
      end
    end
  endtask

  task automatic frame_b(input int base);
    exp_t e;
    for (int r = 0; r < BW_IMG; r++) begin
      for (int c = 0; c < BW_IMG; c++) begin
        @(posedge clk);
        #1;
        b_valid_i = 1'b1;
        b_pix = {pix(base, r, c, 2, BW_IMG), pix(base, r, c, 1, BW_IMG), pix(base, r, c, 0, BW_IMG)};
        if (r >= BK - 1 && c >= BK - 1) begin
          e.fmap = exp_win(base, r, c, BW_IMG, BK, BCI);
          e.done = (r == BW_IMG - 1) && (c == BW_IMG - 1);
          e.cyc  = cyc;
          q_b.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    b_valid_i = 1'b0;
  endtask

  initial begin
    logic [AFW-1:0] ev;

    vec[0] = '{idx: 0,  v: '{0, 1, 2, 8, 9, 10, 16, 17, 18},    done: 1'b0};
    vec[1] = '{idx: 5,  v: '{5, 6, 7, 13, 14, 15, 21, 22, 23},  done: 1'b0};
    vec[2] = '{idx: 6,  v: '{8, 9, 10, 16, 17, 18, 24, 25, 26}, done: 1'b0};
    vec[3] = '{idx: 20, v: '{26, 27, 28, 34, 35, 36, 42, 43, 44}, done: 1'b0};
    vec[4] = '{idx: 35, v: '{45, 46, 47, 53, 54, 55, 61, 62, 63}, done: 1'b1};

    reset_n = 1'b0;
    a_flush = 1'b0; a_valid_i = 1'b0; a_pix = '0;
    b_flush = 1'b0; b_valid_i = 1'b0; b_pix = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(a_valid == 1'b0 && a_done == 1'b0, "reset_a_flags", {a_valid, a_done}, '0);
    check(a_fmap == '0, "reset_a_fmap", 600'(a_fmap), '0);
    check(b_valid == 1'b0 && b_done == 1'b0 && b_fmap == '0, "reset_b", 600'(b_fmap), '0);
    reset_n = 1'b1;

    // 1: continuous ramp
    cap_en = 1'b1;
    frame_a(0, 0, -1, -1);
    idle_a(3);
    cap_en = 1'b0;
    check(cap_f.size() == 36, "t1_window_count", 600'(cap_f.size()), 600'(36));
    check(q_a.size() == 0, "t1_queue_drained", 600'(q_a.size()), '0);
    check(600'(a_fmap) == exp_win(0, 7, 7, AW_IMG, AK, ACI), "t1_fmap_hold", 600'(a_fmap),
          exp_win(0, 7, 7, AW_IMG, AK, ACI));
    for (int i = 0; i < 5; i++) begin
      ev = '0;
      for (int j = 0; j < 9; j++) begin
        ev[j*8 +: 8]      = 8'(vec[i].v[j]);
        ev[72 + j*8 +: 8] = 8'(vec[i].v[j] + 64);
      end
      check(cap_f[vec[i].idx] == ev && cap_d[vec[i].idx] == vec[i].done, "t1_table",
            {cap_f[vec[i].idx], 7'd0, cap_d[vec[i].idx]}, {ev, 7'd0, vec[i].done});
    end

    // 2: random input gaps
    n_win_a = 0;
    frame_a(0, 50, -1, -1);
    idle_a(3);
    check(n_win_a == 36, "t2_window_count", 600'(n_win_a), 600'(36));
    check(q_a.size() == 0, "t2_queue_drained", 600'(q_a.size()), '0);

    // 3: back-to-back frames
    n_win_a = 0; n_done_a = 0;
    frame_a(0, 0, -1, -1);
    frame_a(100, 0, -1, -1);
    idle_a(3);
    check(n_win_a == 72, "t3_window_count", 600'(n_win_a), 600'(72));
    check(n_done_a == 2, "t3_done_count", 600'(n_done_a), 600'(2));
    check(q_a.size() == 0, "t3_queue_drained", 600'(q_a.size()), '0);

    // 4: flush with pixel (4,5)
    frame_a(0, 0, 4, 5);
    drive_a(1'b1, 1'b1, {pix(0, 4, 5, 1, AW_IMG), pix(0, 4, 5, 0, AW_IMG)});
    drive_a(1'b0, 1'b0, '0);
    @(negedge clk);
    check(a_valid == 1'b0 && a_fmap == '0 && a_done == 1'b0, "t4_flush_clears", 600'(a_fmap), '0);
    check(q_a.size() == 0, "t4_preflush_drained", 600'(q_a.size()), '0);
    n_win_a = 0; n_done_a = 0;
    frame_a(50, 0, -1, -1);
    idle_a(3);
    check(n_win_a == 36 && n_done_a == 1, "t4_window_count", 600'({n_win_a, n_done_a}), 600'({32'd36, 32'd1}));
    check(q_a.size() == 0, "t4_queue_drained", 600'(q_a.size()), '0);

    // 5: one-cycle reset mid-frame
    frame_a(0, 0, 3, 4);
    @(posedge clk);
    #1;
    a_valid_i = 1'b0;
    reset_n   = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check(a_valid == 1'b0 && a_fmap == '0 && a_done == 1'b0, "t5_reset_clears", 600'(a_fmap), '0);
    n_win_a = 0;
    frame_a(0, 0, -1, -1);
    idle_a(3);
    check(n_win_a == 36, "t5_window_count", 600'(n_win_a), 600'(36));
    check(q_a.size() == 0, "t5_queue_drained", 600'(q_a.size()), '0);

    // 6: default geometry
    frame_b(0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check(n_win_b == 64, "t6_window_count", 600'(n_win_b), 600'(64));
    check(n_done_b == 1, "t6_done_count", 600'(n_done_b), 600'(1));
    check(q_b.size() == 0, "t6_queue_drained", 600'(q_b.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
